// File: rtl/tlc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlc_pkg
// Brief    : Shared constants for the traffic-light controller BCD entry path.
// Revision : 1.0 - initial release
// ============================================================================
package tlc_pkg;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SHIFT = 1'b1;

    localparam logic [3:0] c_BCD_DIGIT_MAX = 4'd9;
    localparam int         c_BIN_W_DEF     = 7;

endpackage : tlc_pkg
`default_nettype wire

// File: rtl/bcd2bin_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd2bin_seq_if
// Brief    : Start/valid request bundle between a requester and bcd2bin_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd2bin_seq_if #(
    parameter int BIN_W = 7
);

    logic             start;
    logic [3:0]       tens;
    logic [3:0]       ones;
    logic [BIN_W-1:0] binary;
    logic             valid;
    logic             busy;
    logic             err;

    modport master (
        output start, tens, ones,
        input  binary, valid, busy, err
    );

    modport slave (
        input  start, tens, ones,
        output binary, valid, busy, err
    );

endinterface : bcd2bin_seq_if
`default_nettype wire

// File: rtl/bcd_nibble_adj.sv
`default_nettype none
// ============================================================================
// Module   : bcd_nibble_adj
// Brief    : Reverse double-dabble correction: subtract 3 from a nibble >= 8.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_nibble_adj (
    input  wire logic [3:0] i_nib,
    output logic      [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'd8) ? (i_nib - 4'd3) : i_nib;

endmodule : bcd_nibble_adj
`default_nettype wire

// File: rtl/bcd2bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd2bin_seq
// Brief    : Two-digit BCD to binary converter, one reverse double-dabble
//            shift per clock, with start/valid handshake and digit checking.
// Revision : 1.0 - initial release
// ============================================================================
module bcd2bin_seq
    import tlc_pkg::*;
#(
    parameter int BIN_W = c_BIN_W_DEF
) (
    input  wire logic   clk,
    input  wire logic   rst,
    bcd2bin_seq_if.slave bus
);

    localparam int                  c_STEP_W = $clog2(BIN_W + 1);
    localparam logic [c_STEP_W-1:0] c_LAST   = c_STEP_W'(BIN_W - 1);

    logic [0:0]          r_state;
    logic [c_STEP_W-1:0] r_step;
    logic [7:0]          r_bcd;
    logic [BIN_W-1:0]    r_bin;
    logic [BIN_W-1:0]    r_binary;
    logic                r_valid;
    logic                r_err;

    logic                w_digits_ok;
    logic [7:0]          w_bcd_sh;
    logic [7:0]          w_bcd_adj;
    logic [BIN_W-1:0]    w_bin_sh;

    assign w_digits_ok = (bus.tens <= c_BCD_DIGIT_MAX) && (bus.ones <= c_BCD_DIGIT_MAX);

    // BCD LSB falls into the binary MSB; the binary result fills from the top.
    assign w_bcd_sh = {1'b0, r_bcd[7:1]};
    assign w_bin_sh = {r_bcd[0], r_bin[BIN_W-1:1]};

    bcd_nibble_adj u_adj_lo (
        .i_nib (w_bcd_sh[3:0]),
        .o_nib (w_bcd_adj[3:0])
    );

    bcd_nibble_adj u_adj_hi (
        .i_nib (w_bcd_sh[7:4]),
        .o_nib (w_bcd_adj[7:4])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_step   <= '0;
            r_bcd    <= '0;
            r_bin    <= '0;
            r_binary <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        if (w_digits_ok) begin
                            r_bcd   <= {bus.tens, bus.ones};
                            r_bin   <= '0;
                            r_step  <= '0;
                            r_state <= c_SHIFT;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_SHIFT: begin
                    r_bcd  <= w_bcd_adj;
                    r_bin  <= w_bin_sh;
                    r_step <= r_step + 1'b1;
                    if (r_step == c_LAST) begin
                        r_binary <= w_bin_sh;
                        r_valid  <= 1'b1;
                        r_state  <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.binary = r_binary;
    assign bus.valid  = r_valid;
    assign bus.err    = r_err;
    assign bus.busy   = (r_state == c_SHIFT);

endmodule : bcd2bin_seq
`default_nettype wire

// File: tb/tb_bcd2bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd2bin_seq
// Brief    : Directed self-checking bench for bcd2bin_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd2bin_seq;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    bcd2bin_seq_if #(.BIN_W(7)) bus ();

    bcd2bin_seq #(.BIN_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge with start already driven; returns at the negedge
    // where valid is seen (or the budget runs out), reporting busy cycles.
    task automatic wait_valid(output int cyc, output int nbusy);
        cyc   = 0;
        nbusy = 0;
        while (bus.valid !== 1'b1 && cyc < 20) begin
            if (bus.busy === 1'b1) nbusy++;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic issue(input logic [3:0] t, input logic [3:0] o);
        bus.tens  = t;
        bus.ones  = o;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic conv(input logic [3:0] t, input logic [3:0] o,
                        input logic [6:0] exp, input string tag);
        int cyc;
        int nbusy;
        issue(t, o);
        wait_valid(cyc, nbusy);
        chk({tag, "_valid"}, 32'(bus.valid), 32'd1);
        chk({tag, "_bin"},   32'(bus.binary), 32'(exp));
        chk({tag, "_busy0"}, 32'(bus.busy), 32'd0);
        chk({tag, "_lat"},   32'(cyc + 1), 32'd8);
        chk({tag, "_nbusy"}, 32'(nbusy), 32'd7);
    endtask

    initial begin
        int cyc;
        int nbusy;
        int seen;
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.tens  = 4'd0;
        bus.ones  = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_binary", 32'(bus.binary), 32'd0);
        chk("rst_valid",  32'(bus.valid),  32'd0);
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_err",    32'(bus.err),    32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 42 with full latency / busy profile
        conv(4'd4, 4'd2, 7'd42, "c42");
        @(negedge clk);
        chk("c42_valid_drop", 32'(bus.valid), 32'd0);

        // back-to-back: each start issued in the cycle valid is high
        conv(4'd0, 4'd0, 7'd0,  "c00");
        conv(4'd9, 4'd9, 7'd99, "c99");
        conv(4'd3, 4'd1, 7'd31, "c31");
        @(negedge clk);

        // illegal tens digit
        issue(4'hA, 4'd0);
        chk("errA_err",   32'(bus.err),    32'd1);
        chk("errA_busy",  32'(bus.busy),   32'd0);
        chk("errA_valid", 32'(bus.valid),  32'd0);
        chk("errA_bin",   32'(bus.binary), 32'd31);
        @(negedge clk);
        chk("errA_err_drop", 32'(bus.err),   32'd0);
        chk("errA_valid2",   32'(bus.valid), 32'd0);

        // illegal ones digit
        issue(4'd2, 4'hF);
        chk("errF_err",  32'(bus.err),  32'd1);
        chk("errF_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);

        // start during SHIFT is ignored
        issue(4'd5, 4'd5);
        repeat (2) @(negedge clk);
        issue(4'd1, 4'd1);
        wait_valid(cyc, nbusy);
        chk("ign_valid", 32'(bus.valid),  32'd1);
        chk("ign_bin",   32'(bus.binary), 32'd55);
        chk("ign_lat",   32'(cyc + 4),    32'd8);
        @(negedge clk);
        chk("ign_no_second", 32'(bus.busy), 32'd0);

        // digits changed mid-conversion do not matter
        issue(4'd2, 4'd5);
        bus.tens = 4'd8;
        bus.ones = 4'd8;
        wait_valid(cyc, nbusy);
        chk("chg_valid", 32'(bus.valid),  32'd1);
        chk("chg_bin",   32'(bus.binary), 32'd25);
        @(negedge clk);

        // asynchronous reset mid-shift
        issue(4'd7, 4'd3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_binary", 32'(bus.binary), 32'd0);
        chk("arst_busy",   32'(bus.busy),   32'd0);
        chk("arst_valid",  32'(bus.valid),  32'd0);
        chk("arst_err",    32'(bus.err),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.valid === 1'b1) seen++;
        end
        chk("arst_no_valid", 32'(seen), 32'd0);
        conv(4'd1, 4'd2, 7'd12, "c12");
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bcd2bin_seq
`default_nettype wire

// File: doc/bcd2bin_seq.md
# bcd2bin_seq

Sequential BCD-to-binary converter: it accepts a two-digit BCD value (tens, ones) and produces its 7-bit binary equivalent using reverse double-dabble, one shift per clock. It is the inverse of the existing binary-to-BCD display path. The controller uses it to load operator-entered BCD phase durations (switches or keypad) into the binary countdown timers. It rejects non-decimal digits and uses a start/valid handshake.

## Interface
- BIN_W, 7: binary output width and shift count; must be ≥ 7 so 99 fits.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  conversion request; sampled only in IDLE.
- tens  in  4  BCD tens digit; legal range 0–9.
- ones  in  4  BCD ones digit; legal range 0–9.
- binary  out  BIN_W  converted value; holds the last valid result.
- valid  out  1  one-cycle pulse: `binary` was updated this cycle.
- busy  out  1  high while a conversion is in progress.
- err  out  1  one-cycle pulse: the request was rejected (digit > 9).

## Operation
- States:
  - IDLE: wait for `start`.
  - SHIFT: perform BIN_W iterations, counted by a step counter of width ceil(log2(BIN_W+1)).
- IDLE, `start`=1, both digits ≤ 9:
  - load the 8-bit working BCD register with {tens, ones};
  - clear the BIN_W-bit working binary register and the step counter;
  - go to SHIFT.
- IDLE, `start`=1, either digit > 9:
  - stay in IDLE;
  - pulse `err`;
  - leave `binary` unchanged and do not pulse `valid`.
- SHIFT, one iteration per cycle:
  - shift {bcd, bin} right by 1, so the bcd LSB enters the bin MSB;
  - then, for each shifted BCD nibble ≥ 8, subtract 3 from that nibble;
  - increment the step counter.
- SHIFT, on iteration BIN_W:
  - register the final working binary into `binary`;
  - pulse `valid`;
  - return to IDLE.
- `start` during SHIFT is ignored. No queuing; the requester retries after `busy` falls.
- Digits are sampled only on the accepting edge. Changing `tens`/`ones` during SHIFT does not affect the result.
- Arithmetic:
  - the result equals 10·tens + ones, range 0–99, zero-extended to BIN_W;
  - no saturation is needed because BIN_W ≥ 7.
- Reset, asynchronous at any time including mid-SHIFT:
  - state = IDLE;
  - `binary` = 0, `valid` = 0, `busy` = 0, `err` = 0;
  - working registers and counter = 0;
  - the aborted conversion produces no `valid`.

## Timing
- Accepting edge = E0.
- `busy` = 1 from the cycle after E0 through the cycle containing edge E(BIN_W).
- `valid` and the new `binary` are visible in the cycle after E(BIN_W). Latency is 7 cycles for the default.
- `busy` = 0 in the same cycle `valid` = 1. A new `start` may be accepted on the edge ending that cycle, giving one conversion per BIN_W+1 cycles.
- `err` is visible in the cycle after the rejecting edge, lasts one cycle, and `busy` stays 0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package/include `tlc_pkg`:
  - state encoding constants (IDLE, SHIFT);
  - `BCD_DIGIT_MAX` = 9;
  - the `BIN_W` default.
- Sub-module `bcd_nibble_adj`: combinational, 4-bit in, 4-bit out; subtracts 3 when input ≥ 8, otherwise passes the input through. It is instantiated twice, once per nibble.
- The top level holds the FSM, step counter, working registers and output registers.

## Test plan
- tens=4, ones=2, `start` pulse → `busy` for 7 cycles, then `valid`=1 for one cycle with `binary`=42 (0x2A).
- Corners, back-to-back starts, each accepted in the cycle `valid` is high:
  - 0,0 → 0;
  - 9,9 → 99 (0x63);
  - 3,1 → 31.
- tens=10 (0xA), ones=0, `start` → `err` pulse one cycle later, `valid` never asserts, `binary` keeps its previous value, `busy` stays 0.
- Start 5,5, then three cycles later re-assert `start` with 1,1 → the second request is ignored and the result is 55.
- Start 7,3, then assert `rst` for one cycle at step 4 → all outputs 0 immediately. A subsequent start 1,2 → 12 with normal latency.
- Change digits to 8,8 during a 2,5 conversion → result is 25.
